// File: rtl/mpu_fault_monitor.sv
// Qualifies MPU violations with the bus strobe and logs them in a small record FIFO.
// Drives a saturating violation counter, a level interrupt and a sticky lockdown.
module mpu_fault_monitor #(
    parameter int LOG_DEPTH      = 4,
    parameter int LOCK_THRESHOLD = 8,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_valid,
    input  logic [31:0]      addr,
    input  logic             is_write,
    input  logic             is_exec,
    input  logic             privileged_mode,
    input  logic             violation,
    input  logic             log_pop,
    input  logic             clear_req,
    output logic             log_valid,
    output logic [31:0]      log_addr,
    output logic [2:0]       log_flags,
    output logic             log_overflow,
    output logic [CNT_W-1:0] violation_count,
    output logic             fault_irq,
    output logic             lockdown,
    output logic [1:0]       dbg_state
);
    localparam int PTR_W = (LOG_DEPTH > 1) ? $clog2(LOG_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(LOG_DEPTH);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(LOCK_THRESHOLD);

    typedef enum logic [1:0] {IDLE = 2'd0, ALERT = 2'd1, LOCKED = 2'd2} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [34:0]      r_mem [LOG_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;

    logic             w_evt;
    logic             w_empty;
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;
    logic             w_drop;
    logic             w_clr;
    logic [34:0]      w_rec;
    logic [PTR_W-1:0] w_rd_nxt;
    logic [OCC_W-1:0] w_occ_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_ovf_nxt;

    assign w_evt     = mem_valid & violation;
    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == OCC_FULL);
    assign w_do_pop  = log_pop & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = w_evt & (~w_full | w_do_pop);
    assign w_drop    = w_evt & ~w_do_push;
    assign w_clr     = clear_req & (r_state != LOCKED);
    assign w_rec     = {addr, privileged_mode, is_exec, is_write};
    assign w_rd_nxt  = r_rd_ptr + PTR_W'(1);
    assign w_ovf_nxt = (log_overflow & ~w_clr) | w_drop;
    assign dbg_state = r_state;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_do_push && !w_do_pop) begin
            w_occ_nxt = r_occ + OCC_W'(1);
        end else if (w_do_pop && !w_do_push) begin
            w_occ_nxt = r_occ - OCC_W'(1);
        end
    end

    always_comb begin
        w_cnt_nxt = violation_count;
        if (w_clr) begin
            w_cnt_nxt = '0;
        end
        if (w_evt && (w_cnt_nxt != '1)) begin
            w_cnt_nxt = w_cnt_nxt + CNT_W'(1);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_evt) begin
                    w_state_nxt = (w_cnt_nxt >= THRESH) ? LOCKED : ALERT;
                end
            end
            ALERT: begin
                if (w_cnt_nxt >= THRESH) begin
                    w_state_nxt = LOCKED;
                end else if (!w_evt && (w_occ_nxt == '0) && !w_ovf_nxt) begin
                    w_state_nxt = IDLE;
                end
            end
            LOCKED:  w_state_nxt = LOCKED;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_occ           <= '0;
            log_valid       <= 1'b0;
            log_addr        <= '0;
            log_flags       <= '0;
            log_overflow    <= 1'b0;
            violation_count <= '0;
            fault_irq       <= 1'b0;
            lockdown        <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_occ           <= w_occ_nxt;
            log_overflow    <= w_ovf_nxt;
            violation_count <= w_cnt_nxt;
            fault_irq       <= (w_state_nxt != IDLE);
            lockdown        <= (w_state_nxt == LOCKED);
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_nxt;
            end
            // Head register follows storage; it moves only on pop or push-into-empty.
            if (w_do_pop) begin
                if (r_occ > OCC_W'(1)) begin
                    {log_addr, log_flags} <= r_mem[w_rd_nxt];
                    log_valid             <= 1'b1;
                end else if (w_do_push) begin
                    {log_addr, log_flags} <= w_rec;
                    log_valid             <= 1'b1;
                end else begin
                    {log_addr, log_flags} <= '0;
                    log_valid             <= 1'b0;
                end
            end else if (w_do_push && w_empty) begin
                {log_addr, log_flags} <= w_rec;
                log_valid             <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mpu_fault_monitor.sv
// Randomised and directed bench for mpu_fault_monitor, checked against a queue-based
// reference model through an expected-response scoreboard.
module tb_mpu_fault_monitor;
    localparam int LOG_DEPTH = 4;
    localparam int TH        = 8;
    localparam int CNT_MAX   = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] addr = '0;
    logic        is_write = 1'b0;
    logic        is_exec = 1'b0;
    logic        privileged_mode = 1'b0;
    logic        violation = 1'b0;
    logic        log_pop = 1'b0;
    logic        clear_req = 1'b0;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [2:0]  log_flags;
    logic        log_overflow;
    logic [7:0]  violation_count;
    logic        fault_irq;
    logic        lockdown;
    logic [1:0]  dbg_state;

    mpu_fault_monitor #(.LOG_DEPTH(LOG_DEPTH), .LOCK_THRESHOLD(TH), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .addr(addr),
        .is_write(is_write), .is_exec(is_exec), .privileged_mode(privileged_mode),
        .violation(violation), .log_pop(log_pop), .clear_req(clear_req),
        .log_valid(log_valid), .log_addr(log_addr), .log_flags(log_flags),
        .log_overflow(log_overflow), .violation_count(violation_count),
        .fault_irq(fault_irq), .lockdown(lockdown), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Reference model: the fault log as a plain queue plus a few flags.
    logic [34:0] mq[$];
    int          m_cnt;
    bit          m_ovf, m_irq, m_lock;

    // Expected snapshot: {valid, addr[31:0], flags[2:0], ovf, cnt[7:0], irq, lock}
    logic [46:0] exp_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: registered outputs reflect the inputs applied before the last edge.
    initial begin
        logic [46:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("log_valid", {31'b0, log_valid}, {31'b0, e[46]});
                if (e[46]) begin
                    chk("log_addr", log_addr, e[45:14]);
                    chk("log_flags", {29'b0, log_flags}, {29'b0, e[13:11]});
                end
                chk("log_overflow", {31'b0, log_overflow}, {31'b0, e[10]});
                chk("violation_count", {24'b0, violation_count}, {24'b0, e[9:2]});
                chk("fault_irq", {31'b0, fault_irq}, {31'b0, e[1]});
                chk("lockdown", {31'b0, lockdown}, {31'b0, e[0]});
            end
        end
    end

    task automatic step(input bit mv, input bit vi, input logic [31:0] a,
                        input logic [2:0] f, input bit pp, input bit cl);
        bit          evt;
        logic [34:0] h;
        @(negedge clk);
        mem_valid = mv; violation = vi; addr = a;
        privileged_mode = f[2]; is_exec = f[1]; is_write = f[0];
        log_pop = pp; clear_req = cl;
        evt = mv && vi;
        if (pp && mq.size() > 0) void'(mq.pop_front());
        if (cl && !m_lock) begin
            m_cnt = 0;
            m_ovf = 1'b0;
        end
        if (evt) begin
            if (mq.size() < LOG_DEPTH) mq.push_back({a, f});
            else m_ovf = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
            if (m_cnt >= TH) m_lock = 1'b1;
        end
        if (m_lock || evt) m_irq = 1'b1;
        else if (mq.size() == 0 && !m_ovf) m_irq = 1'b0;
        h = (mq.size() > 0) ? mq[0] : 35'b0;
        exp_q.push_back({mq.size() > 0, h, m_ovf, 8'(m_cnt), m_irq, m_lock});
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 3'b000, 0, 0);
    endtask

    // Reset lands mid-cycle, away from any edge, and is checked before the next edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst log_valid", {31'b0, log_valid}, 32'd0);
        chk("rst log_addr", log_addr, 32'd0);
        chk("rst log_flags", {29'b0, log_flags}, 32'd0);
        chk("rst log_overflow", {31'b0, log_overflow}, 32'd0);
        chk("rst violation_count", {24'b0, violation_count}, 32'd0);
        chk("rst fault_irq", {31'b0, fault_irq}, 32'd0);
        chk("rst lockdown", {31'b0, lockdown}, 32'd0);
        mem_valid = 0; violation = 0; addr = '0; is_write = 0; is_exec = 0;
        privileged_mode = 0; log_pop = 0; clear_req = 0;
        mq.delete();
        exp_q.delete();
        m_cnt = 0; m_ovf = 0; m_irq = 0; m_lock = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Single qualified violation, then pop it.
        step(1, 1, 32'h4000_0010, 3'b000, 0, 0);
        step(0, 0, 32'h0, 3'b000, 1, 0);
        idle();

        // Violations without the bus strobe are ignored.
        repeat (5) step(0, 1, $urandom, 3'b111, 0, 0);

        // Overflow with five events into a four-entry log, drain, then clear.
        for (int i = 0; i < 5; i++) step(1, 1, 32'h100 + i, 3'b001, 0, 0);
        repeat (4) step(0, 0, 32'h0, 3'b000, 1, 0);
        idle();
        step(0, 0, 32'h0, 3'b000, 0, 1);
        idle();

        // Push and pop together while full.
        for (int i = 0; i < 4; i++) step(1, 1, 32'h1000 + i, 3'b011, 0, 0);
        step(1, 1, 32'h2000, 3'b010, 1, 0);
        repeat (4) step(0, 0, 32'h0, 3'b000, 1, 0);
        step(0, 0, 32'h0, 3'b000, 0, 1);

        // Lockdown at threshold, clear ignored, counter saturation.
        for (int i = 0; i < 8; i++) begin
            step(1, 1, 32'h3000 + i, 3'b100, 0, 0);
            step(0, 0, 32'h0, 3'b000, 1, 0);
        end
        step(0, 0, 32'h0, 3'b000, 0, 1);
        for (int i = 0; i < 300; i++) step(1, 1, $urandom, 3'($urandom_range(0, 7)), 0, 0);
        step(0, 0, 32'h0, 3'b000, 1, 0);
        idle();
        do_reset();

        // Randomised traffic with periodic resets.
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 200; c++) begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), $urandom,
                     3'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 15) == 0));
            end
            do_reset();
        end

        idle();
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected responses left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
